// File: rtl/cmp_window_stats.sv
// rtl/cmp_window_stats.sv - windowed gt/lt/eq outcome counter with dominance verdict
// Optional sticky illegal-code flag enabled by defining CMP_STATS_ERR_EN.
module cmp_window_stats #(
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             in_ready,
  output logic             busy,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [1:0]       verdict,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] gt_nxt, lt_nxt, eq_nxt;
  logic             legal;
  logic             take_start, take_sample, last_sample;

  function automatic logic [1:0] calc_verdict(input logic [CNT_W-1:0] g,
                                              input logic [CNT_W-1:0] l,
                                              input logic [CNT_W-1:0] e);
    if (g > l && g > e)      return 2'b01;
    else if (l > g && l > e) return 2'b10;
    else if (e > g && e > l) return 2'b11;
    else                     return 2'b00;
  endfunction

  // Odd number of bits set, but not all three, means exactly one is set.
  assign legal  = (gt ^ lt ^ eq) & ~(gt & lt & eq);
  assign gt_nxt = gt_cnt + CNT_W'(legal & gt);
  assign lt_nxt = lt_cnt + CNT_W'(legal & lt);
  assign eq_nxt = eq_cnt + CNT_W'(legal & eq);

  always_comb begin
    state_nxt   = state;
    take_start  = 1'b0;
    take_sample = 1'b0;
    last_sample = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nxt  = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          take_start = 1'b1;
        end else if (in_valid) begin
          take_sample = 1'b1;
          if (idx == LAST_IDX) begin
            last_sample = 1'b1;
            state_nxt   = REPORT;
          end
        end
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign done     = (state == REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      gt_cnt  <= '0;
      lt_cnt  <= '0;
      eq_cnt  <= '0;
      verdict <= 2'b00;
    end else begin
      state <= state_nxt;
      if (take_start) begin
        idx     <= '0;
        gt_cnt  <= '0;
        lt_cnt  <= '0;
        eq_cnt  <= '0;
        verdict <= 2'b00;
      end else if (take_sample) begin
        idx    <= idx + 1'b1;
        gt_cnt <= gt_nxt;
        lt_cnt <= lt_nxt;
        eq_cnt <= eq_nxt;
        // Verdict is computed from the final counts so it is valid during REPORT.
        if (last_sample) verdict <= calc_verdict(gt_nxt, lt_nxt, eq_nxt);
      end
    end
  end

`ifdef CMP_STATS_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err <= 1'b0;
    else if (take_start)            err <= 1'b0;
    else if (take_sample && !legal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_window_stats.sv
// tb/tb_cmp_window_stats.sv - scoreboard bench for cmp_window_stats
module tb_cmp_window_stats;

  localparam int CNT_W = 4;

`ifdef CMP_STATS_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             gt = 1'b0, lt = 1'b0, eq = 1'b0;
  logic             in_ready, busy, done, err;
  logic [CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt;
  logic [1:0]       verdict;

  typedef struct {
    logic [CNT_W-1:0] g;
    logic [CNT_W-1:0] l;
    logic [CNT_W-1:0] e;
    logic [1:0]       v;
    logic             r;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  cmp_window_stats #(.WIN_LEN(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .gt(gt), .lt(lt), .eq(eq), .in_ready(in_ready), .busy(busy),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt),
    .verdict(verdict), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest expected window.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("gt_cnt", 32'(gt_cnt), 32'(x.g));
        chk("lt_cnt", 32'(lt_cnt), 32'(x.l));
        chk("eq_cnt", 32'(eq_cnt), 32'(x.e));
        chk("verdict", 32'(verdict), 32'(x.v));
        chk("err", 32'(err), 32'(x.r));
      end
    end
  end

  task automatic push_exp(input int g, input int l, input int e, input logic [1:0] v, input logic r);
    exp_t x;
    x.g = CNT_W'(g); x.l = CNT_W'(l); x.e = CNT_W'(e); x.v = v; x.r = r;
    exp_q.push_back(x);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drive_sample(input logic [2:0] code);
    int n = 0;
    @(negedge clk);
    start = 1'b0;
    while (!in_ready && n < 20) begin
      in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    {gt, lt, eq} = code;
  endtask

  task automatic send_n(input int n, input logic [2:0] code, input int gap);
    for (int i = 0; i < n; i++) begin
      drive_sample(code);
      repeat (gap) idle_cycle();
    end
  endtask

  // Called right after the last sample is driven: done must follow one cycle later.
  task automatic finish_window(input string name);
    idle_cycle();
    chk({name, "_done_latency"}, 32'(done), 32'd1);
    chk({name, "_busy_report"}, 32'(busy), 32'd1);
    chk({name, "_ready_report"}, 32'(in_ready), 32'd0);
    idle_cycle();
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_counts", 32'({gt_cnt, lt_cnt, eq_cnt}), 32'd0);
    chk("rst_verdict_done_err", 32'({verdict, done, err}), 32'd0);
    rst_n = 1'b1;

    // Reset mid-ACCUM after 3 samples
    do_start();
    send_n(3, 3'b100, 0);
    idle_cycle();
    chk("pre_reset_gt", 32'(gt_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy_ready", 32'({busy, in_ready}), 32'd0);
    chk("midrst_counts", 32'({gt_cnt, lt_cnt, eq_cnt}), 32'd0);
    chk("midrst_verdict_done_err", 32'({verdict, done, err}), 32'd0);
    idle_cycle();
    idle_cycle();
    rst_n = 1'b1;

    // 5 gt, 2 lt, 1 eq back-to-back
    push_exp(5, 2, 1, 2'b01, 1'b0);
    do_start();
    send_n(5, 3'b100, 0);
    send_n(2, 3'b010, 0);
    send_n(1, 3'b001, 0);
    finish_window("w1");
    idle_cycle();
    chk("w1_hold_counts", 32'({gt_cnt, lt_cnt, eq_cnt}), 32'h521);
    chk("w1_hold_verdict", 32'(verdict), 32'd1);

    // 4 gt, 4 lt tie
    push_exp(4, 4, 0, 2'b00, 1'b0);
    do_start();
    send_n(4, 3'b100, 0);
    send_n(4, 3'b010, 0);
    finish_window("w2");

    // 8 eq, with start held during REPORT (must be ignored)
    push_exp(0, 0, 8, 2'b11, 1'b0);
    do_start();
    send_n(8, 3'b001, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    chk("w3_done_latency", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("w3_start_ignored_in_report", 32'(busy), 32'd0);
    chk("w3_hold_eq", 32'(eq_cnt), 32'd8);

    // Restart after 6 samples with gaps; the sample in the restart cycle is dropped
    push_exp(1, 2, 5, 2'b11, 1'b0);
    do_start();
    send_n(6, 3'b100, 1);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    {gt, lt, eq} = 3'b100;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    chk("w4_restart_cleared", 32'(gt_cnt), 32'd0);
    chk("w4_restart_busy", 32'(in_ready), 32'd1);
    send_n(1, 3'b100, 1);
    send_n(2, 3'b010, 2);
    send_n(5, 3'b001, 0);
    finish_window("w4");

    // Two illegal codes among six lt
    push_exp(0, 6, 0, 2'b10, EXP_ERR);
    do_start();
    send_n(3, 3'b010, 0);
    send_n(1, 3'b110, 0);
    send_n(2, 3'b010, 0);
    send_n(1, 3'b000, 0);
    send_n(1, 3'b010, 0);
    finish_window("w5");
    chk("w5_err_sticky", 32'(err), 32'(EXP_ERR));
    do_start();
    idle_cycle();
    chk("w5_err_cleared_by_start", 32'(err), 32'd0);
    chk("w5_start_clears_counts", 32'({gt_cnt, lt_cnt, eq_cnt}), 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("all_windows_reported", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
